// File: rtl/match_sequencer.sv
// Game-flow controller: picks targets, times the show/wait phases,
// scores held cursor hits and declares win or timeout loss.
module match_sequencer #(
  parameter int SHOW_CYCLES    = 12_500_000,
  parameter int TIMEOUT_CYCLES = 75_000_000,
  parameter int HOLD_CYCLES    = 4,
  parameter int MAX_STEP       = 5,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk25MHz,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] match,
  output logic [2:0] step,
  output logic [2:0] variety,
  output logic       showing,
  output logic [7:0] score,
  output logic       win,
  output logic       game_over
);

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    WAIT,
    DONE
  } state_t;

  localparam logic [26:0] SHOW_LAST = 27'(SHOW_CYCLES - 1);
  localparam logic [26:0] TO_LAST   = 27'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [2:0]  LAST_STEP = 3'(MAX_STEP);

  state_t      state;
  logic [7:0]  lfsr;
  logic        start_q;
  logic        go;
  logic [26:0] cnt;
  logic [7:0]  hold;
  logic [2:0]  target;
  logic        same;
  logic        hit;

  // Never place the new target under the cursor.
  function automatic logic [2:0] pick(
    input logic [7:0] l,
    input logic [2:0] m
  );
    logic [1:0] cand;
    cand = l[1:0];
    if (cand == m[1:0]) return {1'b0, cand + 2'd1};
    return {1'b0, cand};
  endfunction

  assign target = pick(lfsr, match);
  assign same   = (match == variety);
  assign hit    = same && (hold == HOLD_LAST);

  always_ff @(posedge clk25MHz or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= LFSR_SEED;
      start_q   <= 1'b0;
      go        <= 1'b0;
      cnt       <= '0;
      hold      <= '0;
      step      <= 3'd0;
      variety   <= 3'b111;
      showing   <= 1'b0;
      score     <= 8'd0;
      win       <= 1'b0;
      game_over <= 1'b0;
    end else begin
      lfsr    <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      start_q <= start;
      go      <= start & ~start_q;
      unique case (state)
        IDLE, DONE: begin
          if (go) begin
            win       <= 1'b0;
            game_over <= 1'b0;
            score     <= 8'd0;
            step      <= 3'd1;
            variety   <= target;
            cnt       <= '0;
            hold      <= '0;
            showing   <= 1'b1;
            state     <= SHOW;
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            cnt     <= '0;
            showing <= 1'b0;
            state   <= WAIT;
          end else begin
            cnt <= cnt + 27'd1;
          end
        end
        WAIT: begin
          if (hit) begin
            if (score != 8'hFF) score <= score + 8'd1;
            if (step == LAST_STEP) begin
              win   <= 1'b1;
              state <= DONE;
            end else begin
              step    <= step + 3'd1;
              variety <= target;
              cnt     <= '0;
              hold    <= '0;
              showing <= 1'b1;
              state   <= SHOW;
            end
          end else if (cnt == TO_LAST) begin
            game_over <= 1'b1;
            state     <= DONE;
          end else begin
            cnt  <= cnt + 27'd1;
            hold <= same ? hold + 8'd1 : 8'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_match_sequencer.sv
// Scoreboard bench for match_sequencer with short show/wait timing.
module tb_match_sequencer;

  localparam int SHOW = 4;
  localparam int TO   = 20;
  localparam int HOLD = 2;
  localparam int MAXS = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] match;
  logic [2:0] step;
  logic [2:0] variety;
  logic       showing;
  logic [7:0] score;
  logic       win;
  logic       game_over;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int cur_tgt;
  logic [7:0] m_lfsr;

  match_sequencer #(
    .SHOW_CYCLES(SHOW),
    .TIMEOUT_CYCLES(TO),
    .HOLD_CYCLES(HOLD),
    .MAX_STEP(MAXS),
    .LFSR_SEED(8'hA5)
  ) dut (
    .clk25MHz(clk),
    .rst(rst),
    .start(start),
    .match(match),
    .step(step),
    .variety(variety),
    .showing(showing),
    .score(score),
    .win(win),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) m_lfsr <= 8'hA5;
    else m_lfsr <= {m_lfsr[6:0],
                    m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int mpick(input logic [7:0] l, input logic [2:0] m);
    int c;
    c = int'(l) % 4;
    if (c == int'(m) % 4) return (c + 1) % 4;
    return c;
  endfunction

  task automatic pop_tgt(input string tag);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 0, 1);
    end else begin
      cur_tgt = exp_q.pop_front();
      chk(tag, variety, cur_tgt);
    end
  endtask

  task automatic start_game();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_q.push_back(mpick(m_lfsr, match));
    @(negedge clk);
    chk("start_step", step, 1);
    chk("start_show", showing, 1);
    chk("start_score", score, 0);
    chk("start_win", win, 0);
    chk("start_over", game_over, 0);
    pop_tgt("start_tgt");
    chk("start_tgt_ne_match", variety != match, 1);
  endtask

  task automatic count_show();
    int n;
    n = showing ? 1 : 0;
    while (showing && n < 50) begin
      @(negedge clk);
      if (showing) n++;
    end
    chk("show_len", n, SHOW);
  endtask

  task automatic do_hit(input int lvl, input int sc);
    match = 3'(cur_tgt);
    @(negedge clk);
    chk("hold1_score", score, sc);
    if (lvl < MAXS) exp_q.push_back(mpick(m_lfsr, match));
    @(negedge clk);
    chk("hit_score", score, sc + 1);
    if (lvl < MAXS) begin
      chk("hit_step", step, lvl + 1);
      pop_tgt("hit_tgt");
      chk("hit_tgt_ne_match", variety != match, 1);
    end else begin
      chk("win", win, 1);
      chk("win_step", step, lvl);
    end
  endtask

  task automatic wait_timeout(input int k0, input int sc);
    int k;
    k = k0;
    while (!game_over && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_len", k, TO);
    chk("timeout_score", score, sc);
    chk("timeout_win", win, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    match = 3'd0;
    #12;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("lfsr", dut.lfsr, m_lfsr);
    end
    chk("idle_step", step, 0);
    chk("idle_var", variety, 7);
    chk("idle_score", score, 0);
    chk("idle_win", win, 0);
    chk("idle_over", game_over, 0);
    chk("idle_show", showing, 0);

    // Game 1: three clean hits to a win
    start_game();
    for (int l = 1; l <= MAXS; l++) begin
      count_show();
      do_hit(l, l - 1);
    end
    for (int i = 0; i < 5; i++) @(negedge clk);
    chk("frozen_step", step, MAXS);
    chk("frozen_score", score, MAXS);
    chk("frozen_var", variety, cur_tgt);
    chk("frozen_win", win, 1);

    // Game 2: one-cycle glitch, then timeout
    start_game();
    count_show();
    match = 3'(cur_tgt);
    @(negedge clk);
    match = 3'((cur_tgt + 1) % 4);
    wait_timeout(1, 0);
    chk("glitch_step", step, 1);

    // Game 3: held through show; hit on the timeout cycle
    start_game();
    match = 3'(cur_tgt);
    count_show();
    chk("show_no_hit", score, 0);
    do_hit(1, 0);
    count_show();
    for (int i = 0; i < TO - 2; i++) @(negedge clk);
    match = 3'(cur_tgt);
    @(negedge clk);
    chk("late_hold1", score, 1);
    exp_q.push_back(mpick(m_lfsr, match));
    @(negedge clk);
    chk("late_hit_score", score, 2);
    chk("late_hit_step", step, 3);
    chk("late_hit_over", game_over, 0);
    pop_tgt("late_hit_tgt");
    count_show();
    wait_timeout(0, 2);

    // Game 4: restart after loss, reset mid-wait at level 2
    start_game();
    count_show();
    do_hit(1, 0);
    count_show();
    for (int i = 0; i < 3; i++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_step", step, 0);
    chk("rst_var", variety, 7);
    chk("rst_show", showing, 0);
    chk("rst_score", score, 0);
    chk("rst_win", win, 0);
    chk("rst_over", game_over, 0);
    chk("rst_lfsr", dut.lfsr, 8'hA5);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("post_rst_step", step, 0);
    chk("post_rst_var", variety, 7);
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
